txt_scan_reader: RTL

Read side of the text video adapter's DMA port. It owns the 80x25 character VRAM and the 640x480@60 timing counters. It accepts character writes from the DMA writer and scans VRAM through an external 8x16 font ROM to produce the 1-bit pixel stream, HS and VS. It also handles cursor underline and blink. It sits inside the VGA adapter between the DMA writer and the board video pins.

---
 rtl/txt_scan_reader_pkg.sv | 39 +++
 rtl/txt_scan_reader_vram.sv | 26 ++
 rtl/txt_scan_reader.sv | 95 +++++++++
 3 files changed

// File: rtl/txt_scan_reader_pkg.sv
// Shared timing bounds, text geometry and scan-pipeline types for the text-mode reader.
package txt_scan_reader_pkg;

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] H_LAST       = 10'd799;

    localparam logic [9:0] V_TEXT_LINES = 10'd400;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;
    localparam logic [9:0] V_LAST       = 10'd524;

    localparam logic [11:0] TXT_CELLS         = 12'd2000;
    localparam logic [3:0]  CURSOR_FIRST_LINE = 4'd14;

    // Per-pixel attributes travelling alongside the VRAM/font fetch.
    typedef struct packed {
        logic       active;
        logic       cursor;
        logic [2:0] bit_sel;
        logic       hs;
        logic       vs;
    } scan_stage_t;

    localparam scan_stage_t STAGE_RESET = '{
        active:  1'b0,
        cursor:  1'b0,
        bit_sel: 3'd0,
        hs:      1'b1,
        vs:      1'b1
    };

    // row*80+col without a multiplier.
    function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
        return ({7'd0, row} << 6) + ({7'd0, row} << 4) + {5'd0, col};
    endfunction

endpackage

// File: rtl/txt_scan_reader_vram.sv
// 2048x8 simple dual-port character RAM; read-first registered read port.
module txt_vram (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [10:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic [10:0] rd_addr,
    output logic [7:0]  rd_data
);

    logic [7:0] mem [2048];

    // Both updates are non-blocking, so a same-edge read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/txt_scan_reader.sv
// 80x25 text scan-out: 640x480@60 timing, VRAM -> external font ROM -> pixel, cursor blink.
module txt_scan_reader
    import txt_scan_reader_pkg::*;
#(
    parameter int BLINK_BIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [11:0] i_vram_addr_wr,
    input  logic [7:0]  i_vram_data_wr,
    input  logic        i_vram_wr_h,
    input  logic [11:0] i_cursor_addr,
    input  logic        i_cursor_en,
    output logic [11:0] o_font_adr,
    input  logic [7:0]  i_font_data,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_video
);

    logic [9:0]  h;
    logic [9:0]  v;
    logic [4:0]  blink_cnt;
    logic [11:0] rd_addr;
    logic [7:0]  vram_q;
    logic        wr_en;
    logic [3:0]  line1;
    scan_stage_t s0, s1, s2, s3;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            h         <= '0;
            v         <= '0;
            blink_cnt <= '0;
        end else begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
            if (h == 10'd0 && v == V_SYNC_START) begin
                blink_cnt <= blink_cnt + 5'd1;
            end
        end
    end

    assign rd_addr = cell_addr(v[8:4], h[9:3]);
    assign wr_en   = i_vram_wr_h && (i_vram_addr_wr < TXT_CELLS);

    always_comb begin
        s0         = STAGE_RESET;
        s0.active  = (h < H_VISIBLE) && (v < V_TEXT_LINES);
        s0.bit_sel = h[2:0];
        // Out-of-range cursor addresses never match a visible cell.
        s0.cursor  = i_cursor_en && (i_cursor_addr < TXT_CELLS) && (i_cursor_addr == rd_addr)
                     && (v[3:0] >= CURSOR_FIRST_LINE) && blink_cnt[BLINK_BIT];
        s0.hs      = !((h >= H_SYNC_START) && (h <= H_SYNC_END));
        s0.vs      = !((v >= V_SYNC_START) && (v <= V_SYNC_END));
    end

    txt_vram u_vram (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .wr_en   (wr_en),
        .wr_addr (i_vram_addr_wr[10:0]),
        .wr_data (i_vram_data_wr),
        .rd_addr (rd_addr[10:0]),
        .rd_data (vram_q)
    );

    // Stage 1 holds VRAM data, stage 2 the font address, stage 3 the font row.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1         <= STAGE_RESET;
            s2         <= STAGE_RESET;
            s3         <= STAGE_RESET;
            line1      <= '0;
            o_font_adr <= '0;
            o_video    <= 1'b0;
            o_hs       <= 1'b1;
            o_vs       <= 1'b1;
        end else begin
            s1         <= s0;
            s2         <= s1;
            s3         <= s2;
            line1      <= v[3:0];
            o_font_adr <= {vram_q, line1};
            o_video    <= s3.active & (i_font_data[3'd7 - s3.bit_sel] ^ s3.cursor);
            o_hs       <= s3.hs;
            o_vs       <= s3.vs;
        end
    end

endmodule
